// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one multi-cycle ALU between NUM_REQ requesters.
//
// Round-robin arbitration picks one requester while idle. The arbiter
// latches that requester's operands, pulses alu_start and waits for
// alu_done. It then returns the result to the owner as a one-cycle
// rsp_valid pulse. Divide-by-zero is answered without touching the ALU,
// and a WAIT timeout aborts an ALU that never completes.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/ready     per-requester handshake (ready is one-hot or zero)
//   req_num1/num2       packed 16-bit operands, slice i = requester i
//   req_op_code         packed 2-bit op codes (00 add, 01 sub, 10 mul, 11 div)
//   rsp_valid           one-hot, one-cycle response pulse to the owner
//   rsp_result          32-bit result of the last completed operation
//   rsp_is_division     last completed operation was a division
//   rsp_err             last operation aborted (div-by-zero or timeout)
//   busy                high whenever the arbiter is not idle
//   grant_id            index of the current or last owner
//   alu_num1/num2/op    operands to the ALU, held until the next acceptance
//   alu_start           one-cycle start pulse to the ALU
//   alu_result/is_div   ALU outputs, sampled when alu_done is high
//   alu_done            ALU completion
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | pick a round-robin winner, accept it, latch its operands
// ISSUE  | alu_start high for this single cycle
// WAIT   | wait for alu_done, count toward the timeout
// RESP   | rsp_valid pulse to the owner, then back to IDLE
module alu_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [16*NUM_REQ-1:0]      req_num1,
  input  logic [16*NUM_REQ-1:0]      req_num2,
  input  logic [2*NUM_REQ-1:0]       req_op_code,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [31:0]                rsp_result,
  output logic                       rsp_is_division,
  output logic                       rsp_err,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [15:0]                alu_num1,
  output logic [15:0]                alu_num2,
  output logic [1:0]                 alu_op_code,
  output logic                       alu_start,
  input  logic [31:0]                alu_result,
  input  logic                       alu_is_division,
  input  logic                       alu_done
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(TIMEOUT_CYCLES);

  localparam logic [IDW:0]         NREQ_EXT = (IDW+1)'(NUM_REQ);
  localparam logic [IDW-1:0]       LAST_ID  = IDW'(NUM_REQ - 1);
  localparam logic [CW-1:0]        TC_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_REQ-1:0]   ONE_HOT0 = NUM_REQ'(1);
  localparam logic [31:0]          ERR_RESULT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [CW-1:0]  wait_cnt;

  logic           win_found;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] next_ptr;
  logic [IDW:0]   cand;
  logic [IDW-1:0] cand_id;
  logic [15:0]    win_num1;
  logic [15:0]    win_num2;
  logic [1:0]     win_op;
  logic           win_div_zero;

  // Search order is rr_ptr, rr_ptr+1, ... wrapping at NUM_REQ; the first
  // valid requester in that order wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    cand_id   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(i);
      if (cand >= NREQ_EXT) cand = cand - NREQ_EXT;
      cand_id = cand[IDW-1:0];
      if (!win_found && req_valid[cand_id]) begin
        win_found = 1'b1;
        win_id    = cand_id;
      end
    end
  end

  always_comb begin
    win_num1 = '0;
    win_num2 = '0;
    win_op   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (win_id == IDW'(j)) begin
        win_num1 = req_num1[16*j +: 16];
        win_num2 = req_num2[16*j +: 16];
        win_op   = req_op_code[2*j +: 2];
      end
    end
  end

  assign win_div_zero = (win_op == 2'b11) && (win_num2 == 16'd0);
  assign next_ptr     = (win_id == LAST_ID) ? '0 : win_id + 1'b1;

  // Gated by rst so that ready reads zero while reset is held.
  assign req_ready = (state == S_IDLE && !rst && win_found) ? (ONE_HOT0 << win_id) : '0;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      rr_ptr          <= '0;
      wait_cnt        <= '0;
      grant_id        <= '0;
      alu_num1        <= '0;
      alu_num2        <= '0;
      alu_op_code     <= '0;
      alu_start       <= 1'b0;
      rsp_valid       <= '0;
      rsp_result      <= '0;
      rsp_is_division <= 1'b0;
      rsp_err         <= 1'b0;
    end else begin
      alu_start <= 1'b0;
      rsp_valid <= '0;
      case (state)
        S_IDLE: begin
          if (win_found) begin
            alu_num1    <= win_num1;
            alu_num2    <= win_num2;
            alu_op_code <= win_op;
            grant_id    <= win_id;
            rr_ptr      <= next_ptr;
            if (win_div_zero) begin
              // Answered locally; the ALU never sees this operation.
              rsp_result      <= ERR_RESULT;
              rsp_is_division <= 1'b1;
              rsp_err         <= 1'b1;
              rsp_valid       <= ONE_HOT0 << win_id;
              state           <= S_RESP;
            end else begin
              alu_start <= 1'b1;
              state     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // Done is checked first so it wins over a same-cycle timeout.
          if (alu_done) begin
            rsp_result      <= alu_result;
            rsp_is_division <= alu_is_division;
            rsp_err         <= 1'b0;
            rsp_valid       <= ONE_HOT0 << grant_id;
            state           <= S_RESP;
          end else if (wait_cnt == TC_LAST) begin
            rsp_result      <= ERR_RESULT;
            rsp_is_division <= (alu_op_code == 2'b11);
            rsp_err         <= 1'b1;
            rsp_valid       <= ONE_HOT0 << grant_id;
            state           <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_RESP: begin
          wait_cnt <= '0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed requests with hand-computed results,
// a behavioural ALU, and a scoreboard queue checked by a separate monitor.
module tb_alu_arbiter;

  localparam int N       = 4;
  localparam int TO      = 8;
  localparam int ALU_LAT = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [16*N-1:0]   req_num1;
  logic [16*N-1:0]   req_num2;
  logic [2*N-1:0]    req_op_code;
  logic [N-1:0]      rsp_valid;
  logic [31:0]       rsp_result;
  logic              rsp_is_division;
  logic              rsp_err;
  logic              busy;
  logic [1:0]        grant_id;
  logic [15:0]       alu_num1;
  logic [15:0]       alu_num2;
  logic [1:0]        alu_op_code;
  logic              alu_start;
  logic [31:0]       alu_result;
  logic              alu_is_division;
  logic              alu_done;

  alu_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_num1        (req_num1),
    .req_num2        (req_num2),
    .req_op_code     (req_op_code),
    .rsp_valid       (rsp_valid),
    .rsp_result      (rsp_result),
    .rsp_is_division (rsp_is_division),
    .rsp_err         (rsp_err),
    .busy            (busy),
    .grant_id        (grant_id),
    .alu_num1        (alu_num1),
    .alu_num2        (alu_num2),
    .alu_op_code     (alu_op_code),
    .alu_start       (alu_start),
    .alu_result      (alu_result),
    .alu_is_division (alu_is_division),
    .alu_done        (alu_done)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
  } req_t;

  typedef struct {
    logic [N-1:0] vld;
    logic [1:0]   gid;
    logic [31:0]  res;
    logic         isdiv;
    logic         err;
    int           lat;
  } exp_t;

  req_t  rq_q[N][$];
  exp_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    last_acc_cyc = -100;
  int    start_cnt = 0;
  bit    alu_hang = 1'b0;
  logic [N-1:0] acc;
  req_t  drv_r;
  exp_t  mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic send(input int r, input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    req_t t;
    t.a = a;
    t.b = b;
    t.op = op;
    rq_q[r].push_back(t);
  endtask

  task automatic expect_rsp(input int r, input logic [31:0] res, input logic isdiv,
                            input logic err, input int lat);
    exp_t e;
    e.vld   = N'(1) << r;
    e.gid   = 2'(r);
    e.res   = res;
    e.isdiv = isdiv;
    e.err   = err;
    e.lat   = lat;
    exp_q.push_back(e);
  endtask

  function automatic bit pending();
    bit p;
    p = (exp_q.size() != 0) || (req_valid != '0);
    for (int i = 0; i < N; i++) if (rq_q[i].size() != 0) p = 1'b1;
    return p;
  endfunction

  task automatic wait_drain(input string name, input int max_cyc);
    int n;
    n = 0;
    while (pending() && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (pending()) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d responses still outstanding after %0d cycles", name, exp_q.size(), n);
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    chk({tag, "_alu_start"}, 32'(alu_start), 32'd0);
    chk({tag, "_alu_ops"}, {alu_num1, alu_num2} | 32'(alu_op_code), 32'd0);
    chk({tag, "_rsp_result"}, rsp_result, 32'd0);
    chk({tag, "_rsp_flags"}, {30'd0, rsp_is_division, rsp_err}, 32'd0);
  endtask

  function automatic logic [31:0] alu_calc(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    logic [31:0] a32;
    logic [31:0] b32;
    a32 = {16'd0, a};
    b32 = {16'd0, b};
    case (op)
      2'b00:   return a32 + b32;
      2'b01:   return a32 - b32;
      2'b10:   return a32 * b32;
      default: return (b32 == 32'd0) ? 32'hFFFF_FFFF : (a32 * 32'd10) / b32;
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Behavioural ALU: done pulses ALU_LAT cycles after start unless hung.
  initial begin
    int          busy_cnt;
    logic [31:0] cap_res;
    logic        cap_div;
    busy_cnt = 0;
    cap_res = '0;
    cap_div = 1'b0;
    alu_done = 1'b0;
    alu_result = '0;
    alu_is_division = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      alu_done = 1'b0;
      if (rst) begin
        busy_cnt = 0;
      end else begin
        if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0 && !alu_hang) begin
            alu_done        = 1'b1;
            alu_result      = cap_res;
            alu_is_division = cap_div;
          end
        end
        if (alu_start) begin
          cap_res  = alu_calc(alu_num1, alu_num2, alu_op_code);
          cap_div  = (alu_op_code == 2'b11);
          busy_cnt = ALU_LAT;
        end
      end
    end
  end

  // Requesters: hold valid and operands until accepted, then load the next op.
  initial begin
    req_valid   = '0;
    req_num1    = '0;
    req_num2    = '0;
    req_op_code = '0;
    forever begin
      @(negedge clk);
      acc = rst ? '0 : (req_valid & req_ready);
      if (acc != '0) begin
        last_acc_cyc = cyc;
        chk("ready_onehot", 32'($countones(req_ready)), 32'd1);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && rq_q[i].size() != 0) begin
          drv_r = rq_q[i].pop_front();
          req_num1[16*i +: 16]  = drv_r.a;
          req_num2[16*i +: 16]  = drv_r.b;
          req_op_code[2*i +: 2] = drv_r.op;
          req_valid[i]          = 1'b1;
        end
      end
    end
  end

  // Monitor: compare every response against the head of the scoreboard.
  initial forever begin
    @(negedge clk);
    if (!rst && alu_start) begin
      start_cnt++;
      chk("start_latency", 32'(cyc - last_acc_cyc), 32'd1);
    end
    if (!rst && rsp_valid != '0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: rsp_valid=%b result=0x%0h with nothing expected", rsp_valid, rsp_result);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'(mon_e.vld));
        chk("grant_id", 32'(grant_id), 32'(mon_e.gid));
        chk("rsp_result", rsp_result, mon_e.res);
        chk("rsp_is_division", 32'(rsp_is_division), 32'(mon_e.isdiv));
        chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
        chk("rsp_latency", 32'(cyc - last_acc_cyc), 32'(mon_e.lat));
      end
    end
  end

  initial begin
    int sc;
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Round robin from pointer 0: grants 0,1,2,3,0.
    send(0, 16'd20, 16'd8, 2'b01);
    send(0, 16'd7, 16'd3, 2'b00);
    send(1, 16'd12, 16'd120, 2'b10);
    send(2, 16'd15, 16'd5, 2'b00);
    send(3, 16'd15, 16'd2, 2'b11);
    expect_rsp(0, 32'd12, 1'b0, 1'b0, 5);
    expect_rsp(1, 32'd1440, 1'b0, 1'b0, 5);
    expect_rsp(2, 32'd20, 1'b0, 1'b0, 5);
    expect_rsp(3, 32'd75, 1'b1, 1'b0, 5);
    expect_rsp(0, 32'd10, 1'b0, 1'b0, 5);
    wait_drain("round_robin", 200);

    send(0, 16'd15, 16'd15, 2'b00);
    expect_rsp(0, 32'd30, 1'b0, 1'b0, 5);
    wait_drain("single", 50);

    send(2, 16'd135, 16'd7, 2'b11);
    expect_rsp(2, 32'd192, 1'b1, 1'b0, 5);
    wait_drain("division", 50);

    sc = start_cnt;
    send(1, 16'd9, 16'd0, 2'b11);
    expect_rsp(1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1);
    wait_drain("div_zero", 50);
    chk("div_zero_no_start", 32'(start_cnt), 32'(sc));

    // Hung ALU: 8 WAIT cycles then error response (accept to rsp = 10).
    alu_hang = 1'b1;
    send(3, 16'd1, 16'd2, 2'b00);
    expect_rsp(3, 32'hFFFF_FFFF, 1'b0, 1'b1, 10);
    wait_drain("timeout", 50);
    alu_hang = 1'b0;
    send(1, 16'd100, 16'd1, 2'b01);
    expect_rsp(1, 32'd99, 1'b0, 1'b0, 5);
    wait_drain("after_timeout", 50);

    // Reset while waiting on a hung ALU drops the op silently.
    alu_hang = 1'b1;
    send(1, 16'd5, 16'd5, 2'b00);
    n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk("mid_wait_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) @(negedge clk);
    check_reset_outputs("mid_reset_hold");
    rst = 1'b0;
    alu_hang = 1'b0;
    send(2, 16'd3, 16'd4, 2'b10);
    send(0, 16'd50, 16'd20, 2'b01);
    expect_rsp(0, 32'd30, 1'b0, 1'b0, 5);
    expect_rsp(2, 32'd12, 1'b0, 1'b0, 5);
    wait_drain("post_reset", 100);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
